// File: rtl/zero_one_scheduler.sv
// Serializes a parallel word MSB-first into the zero_one_detector, collects det_y
// per bit through a latency-matched tag pipeline and returns hit count and hit map.
module zero_one_scheduler #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned DET_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              det_a,
  output logic              det_rst,
  input  logic              det_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_hits,
  output logic              busy
);

  localparam int unsigned IDX_W  = $clog2(WORD_W);
  localparam int unsigned BCNT_W = $clog2(WORD_W + 1);
  localparam logic [1:0]  DRAIN_LAST = (DET_LAT > 0) ? 2'(DET_LAT - 1) : 2'd0;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   shreg, shreg_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic [1:0]          dcnt, dcnt_n;
  logic                det_a_n;
  logic                launch;
  logic [IDX_W-1:0]    launch_idx;
  logic [CNT_W-1:0]    count_n;
  logic [WORD_W-1:0]   hits_n;

  // Tag pipeline: stage 0 is loaded on the edge a bit is driven, the last stage
  // lines up with the edge its det_y response is valid.
  logic [DET_LAT:0]            tag_v;
  logic [DET_LAT:0][IDX_W-1:0] tag_i;

  assign launch_idx = IDX_W'(WORD_W - 32'd1 - 32'(bcnt));

  // Next-state, datapath and sampling
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    dcnt_n  = dcnt;
    det_a_n = 1'b0;
    launch  = 1'b0;
    count_n = out_count;
    hits_n  = out_hits;

    if (tag_v[DET_LAT] && det_y) begin
      count_n = out_count + CNT_W'(1);
      hits_n[tag_i[DET_LAT]] = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          shreg_n = in_word;
          bcnt_n  = '0;
          count_n = '0;
          hits_n  = '0;
          state_n = CLEAR;
        end
      end
      CLEAR, SHIFT: begin
        if (bcnt == BCNT_W'(WORD_W)) begin
          dcnt_n  = '0;
          state_n = (DET_LAT > 0) ? DRAIN : DONE;
        end else begin
          det_a_n = shreg[WORD_W-1];
          shreg_n = shreg << 1;
          bcnt_n  = bcnt + BCNT_W'(1);
          launch  = 1'b1;
          state_n = SHIFT;
        end
      end
      DRAIN: begin
        dcnt_n = dcnt + 2'd1;
        if (dcnt == DRAIN_LAST) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      det_a     <= 1'b0;
      det_rst   <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_hits  <= '0;
      tag_v     <= '0;
      tag_i     <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bcnt      <= bcnt_n;
      dcnt      <= dcnt_n;
      in_ready  <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      det_a     <= det_a_n;
      det_rst   <= (state_n == CLEAR);
      out_valid <= (state_n == DONE);
      out_count <= count_n;
      out_hits  <= hits_n;
      tag_v[0]  <= launch;
      tag_i[0]  <= launch_idx;
      for (int i = 1; i <= int'(DET_LAT); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
    end
  end

endmodule

// File: tb/tb_zero_one_scheduler.sv
// Bench for zero_one_scheduler: behavioural detector (Y = A & previous A was 0),
// expected results computed from the word and queued at accept, checked at output.
module tb_zero_one_scheduler;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int          LAT    = 17;  // accept edge to first out_valid edge

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_word = '0;
  logic              det_a;
  logic              det_rst;
  logic              det_y;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_hits;
  logic              busy;

  typedef struct {
    logic [CNT_W-1:0]  c;
    logic [WORD_W-1:0] h;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  zero_one_scheduler #(.WORD_W(WORD_W), .CNT_W(CNT_W), .DET_LAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .det_a(det_a), .det_rst(det_rst), .det_y(det_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_hits(out_hits), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector model: combinational Y, history cleared by det_rst
  logic has_prev = 1'b0;
  logic prev_a = 1'b0;
  always @(posedge clk) begin
    if (det_rst) has_prev <= 1'b0;
    else begin
      has_prev <= 1'b1;
      prev_a   <= det_a;
    end
  end
  assign det_y = det_a & has_prev & ~prev_a;

  function automatic exp_t expect_of(input logic [WORD_W-1:0] w);
    exp_t e;
    e.c = '0;
    e.h = '0;
    for (int i = 0; i < int'(WORD_W) - 1; i++)
      if (w[i] && !w[i+1]) begin
        e.h[i] = 1'b1;
        e.c    = e.c + CNT_W'(1);
      end
    return e;
  endfunction

  // Offer a word until accepted; returns the cycle stamp just after the accept edge
  task automatic send(input logic [WORD_W-1:0] w, output int acc, output bit ok);
    logic rdy;
    ok = 1'b0;
    acc = 0;
    in_word = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready;
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) begin
      acc = cyc;
      sb.push_back(expect_of(w));
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word=%h in_ready never high", w);
    end
  endtask

  task automatic wait_valid(output int vcyc, output bit ok);
    ok = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        vcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout out_valid never high");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Send a word, wait for its result, capture it and complete the handshake
  task automatic run_word(input logic [WORD_W-1:0] w, output logic [CNT_W-1:0] c,
                          output logic [WORD_W-1:0] h, output int lat, output bit ok);
    int acc, vcyc;
    bit ok1, ok2;
    c = '0;
    h = '0;
    lat = -1;
    send(w, acc, ok1);
    ok2 = 1'b0;
    if (ok1) wait_valid(vcyc, ok2);
    ok = ok1 && ok2;
    if (ok) begin
      c = out_count;
      h = out_hits;
      lat = vcyc - acc;
      handshake();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_word = 16'h4000;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_out_count got=%0d want=0", out_count); end
    checks++; if (out_hits !== '0) begin errors++; $display("FAIL reset_out_hits got=%h want=0000", out_hits); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL reset_det_rst got=%b want=1", det_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (det_a !== 1'b0) begin errors++; $display("FAIL reset_det_a got=%b want=0", det_a); end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    checks++; if (busy !== 1'b0 || det_rst !== 1'b0) begin
      errors++; $display("FAIL idle_flags busy=%b det_rst=%b want 0/0", busy, det_rst);
    end
  endtask

  task automatic test_single();
    logic [CNT_W-1:0] c; logic [WORD_W-1:0] h; int lat; bit ok; exp_t e;
    run_word(16'b0100_0000_0000_0000, c, h, lat, ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (c !== e.c) begin errors++; $display("FAIL single_count got=%0d want=%0d", c, e.c); end
      checks++; if (h !== e.h) begin errors++; $display("FAIL single_hits got=%h want=%h", h, e.h); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL single_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL single_return_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_patterns();
    logic [WORD_W-1:0] words [2];
    logic [CNT_W-1:0] c; logic [WORD_W-1:0] h; int lat; bit ok; exp_t e;
    words[0] = 16'h5555;
    words[1] = 16'hAAAA;
    for (int i = 0; i < 2; i++) begin
      run_word(words[i], c, h, lat, ok);
      if (ok) begin
        e = sb.pop_front();
        checks++; if (c !== e.c) begin errors++; $display("FAIL pattern_count word=%h got=%0d want=%0d", words[i], c, e.c); end
        checks++; if (h !== e.h) begin errors++; $display("FAIL pattern_hits word=%h got=%h want=%h", words[i], h, e.h); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL pattern_latency word=%h got=%0d want=%0d", words[i], lat, LAT); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c; logic [WORD_W-1:0] h; int lat, acc, vcyc; bit ok, ok2; exp_t e;
    send(16'hFFFF, acc, ok);
    if (ok) wait_valid(vcyc, ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (out_count !== e.c || out_hits !== e.h) begin
        errors++; $display("FAIL b2b_first got=%0d/%h want=%0d/%h", out_count, out_hits, e.c, e.h);
      end
      handshake();
      run_word(16'h0000, c, h, lat, ok2);
      if (ok2) begin
        e = sb.pop_front();
        checks++; if (c !== e.c || h !== e.h) begin
          errors++; $display("FAIL b2b_second got=%0d/%h want=%0d/%h", c, h, e.c, e.h);
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
      end
    end
    // Immediate follow-on: accept edge must be the one right after the handshake edge
    send(16'h0F0F, acc, ok);
    if (ok) begin
      wait_valid(vcyc, ok2);
      if (ok2) begin
        e = sb.pop_front();
        checks++; if (out_count !== e.c || out_hits !== e.h) begin
          errors++; $display("FAIL b2b_third got=%0d/%h want=%0d/%h", out_count, out_hits, e.c, e.h);
        end
        handshake();
        send(16'h1234, acc, ok);
        checks++; if (!ok || acc !== vcyc + 2) begin
          errors++; $display("FAIL b2b_gap got_accept=%0d want=%0d", acc, vcyc + 2);
        end
        if (ok) begin
          wait_valid(vcyc, ok2);
          if (ok2) begin
            e = sb.pop_front();
            checks++; if (out_count !== e.c || out_hits !== e.h) begin
              errors++; $display("FAIL b2b_fourth got=%0d/%h want=%0d/%h", out_count, out_hits, e.c, e.h);
            end
            handshake();
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, vcyc; bit ok; exp_t e; int bad;
    send(16'h5555, acc, ok);
    if (ok) wait_valid(vcyc, ok);
    if (ok) begin
      e = sb.pop_front();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_count !== e.c || out_hits !== e.h || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin
        errors++; $display("FAIL hold_stable bad_cycles=%0d want=0 (last %b %0d %h ready=%b)", bad, out_valid, out_count, out_hits, in_ready);
      end
      handshake();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL release_idle out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
      end
      checks++; if (out_count !== e.c || out_hits !== e.h) begin
        errors++; $display("FAIL release_keep got=%0d/%h want=%0d/%h", out_count, out_hits, e.c, e.h);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [CNT_W-1:0] c; logic [WORD_W-1:0] h; int lat, acc, seen; bit ok; exp_t e;
    send(16'h5555, acc, ok);
    if (ok) begin
      repeat (8) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || det_rst !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL midrst_state out_valid=%b busy=%b det_rst=%b in_ready=%b want 0/0/1/0", out_valid, busy, det_rst, in_ready);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_result out_valid_cycles=%0d want=0", seen); end
      run_word(16'h5555, c, h, lat, ok);
      if (ok) begin
        e = sb.pop_front();
        checks++; if (c !== e.c || h !== e.h) begin
          errors++; $display("FAIL midrst_resend got=%0d/%h want=%0d/%h", c, h, e.c, e.h);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] c; logic [WORD_W-1:0] h, w; int lat; bit ok; exp_t e;
    for (int i = 0; i < 6; i++) begin
      w = WORD_W'($urandom);
      run_word(w, c, h, lat, ok);
      if (ok) begin
        e = sb.pop_front();
        checks++; if (c !== e.c || h !== e.h || lat !== LAT) begin
          errors++; $display("FAIL random word=%h got=%0d/%h lat=%0d want=%0d/%h lat=%0d", w, c, h, lat, e.c, e.h, LAT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    test_random();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
